// File: rtl/synth_param_pkg.sv
// Shared constants, per-parameter defaults/limits/steps and the auto-repeat state type
// for the synthesiser parameter bank.
package synth_param_pkg;

  localparam int P_OCTAVE  = 0;
  localparam int P_AMP     = 1;
  localparam int P_ATTACK  = 2;
  localparam int P_DECAY   = 3;
  localparam int P_SUSTAIN = 4;
  localparam int P_RELEASE = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } rpt_state_e;

  function automatic logic [63:0] PARAM_DEFAULT(input int i);
    case (i)
      P_OCTAVE:                               return 64'd4;
      P_AMP, P_ATTACK, P_SUSTAIN, P_RELEASE:  return 64'd1 << 30;
      default:                                return 64'd0;
    endcase
  endfunction

  // Indices beyond the named set span the full register width.
  function automatic logic [63:0] PARAM_MAX(input int i, input int w);
    case (i)
      P_OCTAVE:                                       return 64'd7;
      P_AMP, P_ATTACK, P_DECAY, P_SUSTAIN, P_RELEASE: return 64'd1 << 30;
      default:                                        return (64'd1 << w) - 64'd1;
    endcase
  endfunction

  function automatic logic [63:0] PARAM_STEP(input int i);
    case (i)
      P_OCTAVE:                                       return 64'd1;
      P_AMP, P_ATTACK, P_DECAY, P_SUSTAIN, P_RELEASE: return 64'd1 << 24;
      default:                                        return 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/synth_param_repeat.sv
// Press-edge / hold / auto-repeat sequencer; emits a one-cycle step_en_o with the
// direction and parameter index latched when the press was accepted.
module synth_param_repeat
  import synth_param_pkg::*;
#(
  parameter int NUM_PARAMS   = 6,
  parameter int SEL_W        = 3,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic             step_en_o,
  output logic             dir_o,
  output logic [SEL_W-1:0] idx_o
);

  localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1;
  localparam logic [CNT_W-1:0] DLY_M1  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_M1 = CNT_W'(REPEAT_RATE - 1);

  rpt_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inc_q, dec_q, dir_q, step_en_q;
  logic [SEL_W-1:0] sel_q;

  logic req, press, sel_ok, hold_ok;

  assign req     = inc_i ^ dec_i;
  assign press   = (inc_i & ~inc_q) | (dec_i & ~dec_q);
  assign sel_ok  = int'(sel_i) < NUM_PARAMS;
  // Any change of key, direction or target abandons the hold without a step.
  assign hold_ok = req && (inc_i == dir_q) && (sel_i == sel_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      dir_q     <= 1'b0;
      sel_q     <= '0;
      step_en_q <= 1'b0;
    end else begin
      inc_q     <= inc_i;
      dec_q     <= dec_i;
      step_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req && press && sel_ok) begin
            step_en_q <= 1'b1;
            dir_q     <= inc_i;
            sel_q     <= sel_i;
            cnt_q     <= '0;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!hold_ok) begin
            state_q <= S_IDLE;
          end else if (cnt_q == DLY_M1) begin
            step_en_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_REPEAT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (!hold_ok) begin
            state_q <= S_IDLE;
          end else if (cnt_q == RATE_M1) begin
            step_en_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign step_en_o = step_en_q;
  assign dir_o     = dir_q;
  assign idx_o     = sel_q;

endmodule

// File: rtl/synth_param_bank.sv
// Synthesiser parameter register bank with saturating step arithmetic.
// Define SYNTH_PARAM_WRAP_EN to make steps wrap around instead of saturating.
module synth_param_bank
  import synth_param_pkg::*;
#(
  parameter int NUM_PARAMS   = 6,
  parameter int WIDTH        = 31,
  parameter int SEL_W        = 3,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [SEL_W-1:0]            sel_i,
  input  logic                        inc_i,
  input  logic                        dec_i,
  output logic [NUM_PARAMS*WIDTH-1:0] params_flat_o,
  output logic                        changed_o,
  output logic [SEL_W-1:0]            changed_idx_o,
  output logic                        at_limit_o
);

  logic             step_en, step_dir;
  logic [SEL_W-1:0] step_idx;

  synth_param_repeat #(
    .NUM_PARAMS  (NUM_PARAMS),
    .SEL_W       (SEL_W),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_repeat (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sel_i    (sel_i),
    .inc_i    (inc_i),
    .dec_i    (dec_i),
    .step_en_o(step_en),
    .dir_o    (step_dir),
    .idx_o    (step_idx)
  );

  logic [WIDTH-1:0] val_q [NUM_PARAMS];
  logic             changed_q;
  logic [SEL_W-1:0] changed_idx_q;

  logic [WIDTH-1:0] tgt_v, tgt_max, tgt_step, new_val_d, sel_v, sel_max;
  logic [WIDTH:0]   sum_w;
  logic             chg_d;

  always_comb begin
    tgt_v = '0;
    sel_v = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (step_idx == SEL_W'(i)) tgt_v = val_q[i];
      if (sel_i == SEL_W'(i))    sel_v = val_q[i];
    end
    tgt_max  = WIDTH'(PARAM_MAX(int'(step_idx), WIDTH));
    tgt_step = WIDTH'(PARAM_STEP(int'(step_idx)));
    sel_max  = WIDTH'(PARAM_MAX(int'(sel_i), WIDTH));
    // One extra bit so v+s cannot overflow before the limit compare.
    sum_w    = {1'b0, tgt_v} + {1'b0, tgt_step};
`ifdef SYNTH_PARAM_WRAP_EN
    if (step_dir) new_val_d = (sum_w > {1'b0, tgt_max}) ? '0 : sum_w[WIDTH-1:0];
    else          new_val_d = (tgt_v < tgt_step) ? tgt_max : tgt_v - tgt_step;
    chg_d      = step_en;
    at_limit_o = 1'b0;
`else
    if (step_dir) new_val_d = (sum_w > {1'b0, tgt_max}) ? tgt_max : sum_w[WIDTH-1:0];
    else          new_val_d = (tgt_v < tgt_step) ? '0 : tgt_v - tgt_step;
    chg_d      = step_en && (new_val_d != tgt_v);
    at_limit_o = (int'(sel_i) < NUM_PARAMS) && ((sel_v == '0) || (sel_v == sel_max));
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_PARAMS; i++) val_q[i] <= WIDTH'(PARAM_DEFAULT(i));
      changed_q     <= 1'b0;
      changed_idx_q <= '0;
    end else begin
      changed_q <= chg_d;
      if (chg_d) begin
        changed_idx_q <= step_idx;
        for (int i = 0; i < NUM_PARAMS; i++)
          if (step_idx == SEL_W'(i)) val_q[i] <= new_val_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
    assign params_flat_o[g*WIDTH +: WIDTH] = val_q[g];
  end

  assign changed_o     = changed_q;
  assign changed_idx_o = changed_idx_q;

endmodule

// File: tb/tb_synth_param_bank.sv
// Randomised scoreboard bench for synth_param_bank with short repeat timings.
module tb_synth_param_bank;

  localparam int NP = 6;
  localparam int W  = 31;
  localparam int SW = 3;
  localparam int RD = 10;
  localparam int RR = 4;

  localparam longint P30 = 64'd1 << 30;
  localparam longint P24 = 64'd1 << 24;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [SW-1:0]   sel = '0;
  logic            inc = 1'b0;
  logic            dec = 1'b0;
  logic [NP*W-1:0] params_flat;
  logic            changed;
  logic [SW-1:0]   changed_idx;
  logic            at_limit;

  synth_param_bank #(
    .NUM_PARAMS  (NP),
    .WIDTH       (W),
    .SEL_W       (SW),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .sel_i        (sel),
    .inc_i        (inc),
    .dec_i        (dec),
    .params_flat_o(params_flat),
    .changed_o    (changed),
    .changed_idx_o(changed_idx),
    .at_limit_o   (at_limit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint pval(input int i);
    logic [W-1:0] v;
    v = params_flat[i*W +: W];
    return longint'(v);
  endfunction

  // Reference tables written straight from the parameter definitions.
  longint DEF [NP] = '{4, P30, P30, 0, P30, P30};
  longint MAXV[NP] = '{7, P30, P30, P30, P30, P30};
  longint STP [NP] = '{1, P24, P24, P24, P24, P24};

  typedef struct { int idx; longint val; } exp_t;
  exp_t   exp_q[$];
  longint mv[NP];
  bit     p_inc, p_dec, active, h_dir, pend;
  int     h_n, h_sel, pend_idx;
  longint pend_val;

  // Model: a press steps at once, then every hold duration 1+RD+k*RR edges steps again.
  task automatic model_step(input int s, input bit up);
    longint v, nv;
    bit ch;
    v = mv[s];
`ifdef SYNTH_PARAM_WRAP_EN
    if (up) nv = (v + STP[s] > MAXV[s]) ? 0 : v + STP[s];
    else    nv = (v < STP[s]) ? MAXV[s] : v - STP[s];
    ch = 1'b1;
`else
    if (up) nv = (v + STP[s] > MAXV[s]) ? MAXV[s] : v + STP[s];
    else    nv = (v < STP[s]) ? 0 : v - STP[s];
    ch = (nv != v);
`endif
    if (ch) begin
      exp_q.push_back('{idx: s, val: nv});
      pend = 1'b1; pend_idx = s; pend_val = nv;
    end
  endtask

  always @(posedge clk) begin
    bit req, do_step;
    if (reset) begin
      for (int i = 0; i < NP; i++) mv[i] = DEF[i];
      p_inc = 0; p_dec = 0; active = 0; pend = 0;
      exp_q.delete();
    end else begin
      if (pend) begin mv[pend_idx] = pend_val; pend = 0; end
      do_step = 0;
      req = inc ^ dec;
      if (active) begin
        if (!req || inc != h_dir || int'(sel) != h_sel) active = 0;
        else begin
          h_n++;
          if (h_n - 1 - RD >= 0 && (h_n - 1 - RD) % RR == 0) do_step = 1;
        end
      end else if (req && int'(sel) < NP && ((inc && !p_inc) || (dec && !p_dec))) begin
        active = 1; h_n = 1; h_dir = inc; h_sel = int'(sel); do_step = 1;
      end
      if (do_step) model_step(h_sel, h_dir);
      p_inc = inc; p_dec = dec;
    end
  end

  // Monitor: consumes one expected change per changed pulse; checks at_limit every cycle.
  always @(negedge clk) begin
    exp_t e;
    longint exp_lim;
    if (!reset) begin
      if (changed) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: got idx %0d val %0d expected no change",
                   changed_idx, pval(int'(changed_idx)));
        end else begin
          e = exp_q.pop_front();
          chk("changed_idx", longint'(changed_idx), longint'(e.idx));
          chk("changed_val", pval(e.idx), e.val);
        end
      end
`ifdef SYNTH_PARAM_WRAP_EN
      exp_lim = 0;
`else
      exp_lim = (int'(sel) < NP && (mv[sel] == 0 || mv[sel] == MAXV[sel])) ? 1 : 0;
`endif
      chk("at_limit", longint'(at_limit), exp_lim);
    end
  end

  task automatic drive(input bit i, input bit d, input int s, input int n);
    inc = i; dec = d; sel = SW'(s);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 2);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, m, n, k;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < NP; i++) chk($sformatf("default_p%0d", i), pval(i), DEF[i]);
    chk("reset_changed", longint'(changed), 0);
    chk("reset_changed_idx", longint'(changed_idx), 0);

    repeat (4) begin drive(1, 0, 0, 1); drive(0, 0, 0, 2); end
`ifdef SYNTH_PARAM_WRAP_EN
    chk("octave_after_4", pval(0), 0);
    chk("octave_at_limit", longint'(at_limit), 0);
`else
    chk("octave_after_4", pval(0), 7);
    chk("octave_at_limit", longint'(at_limit), 1);
`endif

    drive(0, 1, 3, 1); drive(0, 0, 3, 2);
`ifndef SYNTH_PARAM_WRAP_EN
    chk("decay_underflow", pval(3), 0);
    chk("decay_at_limit", longint'(at_limit), 1);
`endif

    drive(0, 1, 1, 30); drive(0, 0, 1, 2);
    chk("amp_autorepeat", pval(1), P30 - 6 * P24);

    drive(1, 1, 2, 5); drive(0, 0, 2, 1);
    chk("both_keys_attack", pval(2), P30);
    drive(0, 1, 2, 3); drive(0, 1, 4, 20); drive(0, 0, 4, 1);
    chk("sel_change_attack", pval(2), P30 - P24);
    chk("sel_change_sustain", pval(4), P30);
    drive(0, 1, 4, 1); drive(0, 0, 4, 2);
    chk("repress_sustain", pval(4), P30 - P24);

    for (int it = 0; it < 250; it++) begin
      s = $urandom_range(0, 7);
      m = $urandom_range(0, 9);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 24) : $urandom_range(1, 4);
      case (m)
        0, 1, 2: drive(1, 0, s, n);
        3, 4, 5: drive(0, 1, s, n);
        6:       drive(1, 1, s, n);
        7: begin
          k = $urandom_range(0, 1);
          drive(k, !k, s, n);
          drive(k, !k, $urandom_range(0, 7), $urandom_range(1, 8));
        end
        8: begin
          drive(1, 0, s, n);
          drive(0, 1, s, $urandom_range(1, 6));
        end
        default: drive(0, 0, s, n);
      endcase
      drive(0, 0, s, $urandom_range(1, 2));
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    drive(0, 0, 0, 3);
    chk("queue_drained", longint'(exp_q.size()), 0);
    for (int i = 0; i < NP; i++) chk($sformatf("final_p%0d", i), pval(i), mv[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
